// File: rtl/config_chain_loader.sv
// Serial config-chain loader: streams bitstream words LSB-first into the tile chain, then pulses done.
// Optional readback of the old chain content is enabled with CONFIG_CHAIN_LOADER_READBACK_EN.
module config_chain_loader #(
  parameter int unsigned CHAIN_LENGTH = 240,
  parameter int unsigned WORD_WIDTH   = 8
) (
  input  logic                  config_clock,
  input  logic                  config_reset,
  input  logic                  start,
  input  logic                  clear_chain,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  chain_out,
  output logic                  chain_enable,
  output logic                  chain_nreset,
  input  logic                  chain_in,
`ifdef CONFIG_CHAIN_LOADER_READBACK_EN
  output logic [WORD_WIDTH-1:0] readback_data,
  output logic                  readback_valid,
`endif
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned CNT_W = $clog2(CHAIN_LENGTH + 1);
  localparam int unsigned IDX_W = $clog2(WORD_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LENGTH - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t                r_state;
  logic [WORD_WIDTH-1:0] r_shreg;
  logic [IDX_W-1:0]      r_bit_idx;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic                  r_chain_out;
  logic                  r_chain_enable;
  logic                  r_chain_nreset;
  logic                  r_done;
  logic                  w_last_bit;
  logic                  w_word_end;

  // The current shift edge either completes the whole chain or the current word.
  assign w_last_bit = (r_bit_cnt == LAST_CNT);
  assign w_word_end = w_last_bit || (r_bit_idx == LAST_IDX);

  always_ff @(posedge config_clock or posedge config_reset) begin
    if (config_reset) begin
      r_state        <= ST_IDLE;
      r_shreg        <= '0;
      r_bit_idx      <= '0;
      r_bit_cnt      <= '0;
      r_chain_out    <= 1'b0;
      r_chain_enable <= 1'b0;
      r_chain_nreset <= 1'b1;
      r_done         <= 1'b0;
    end else begin
      r_done         <= 1'b0;
      r_chain_nreset <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_bit_cnt <= '0;
            if (clear_chain) begin
              r_state        <= ST_CLEAR;
              r_chain_nreset <= 1'b0;
            end else begin
              r_state <= ST_LOAD;
            end
          end
        end
        ST_CLEAR: r_state <= ST_LOAD;
        ST_LOAD: begin
          // Bit 0 goes out straight away; the rest waits in the shift register.
          if (word_valid) begin
            r_state        <= ST_SHIFT;
            r_shreg        <= word_data >> 1;
            r_chain_out    <= word_data[0];
            r_chain_enable <= 1'b1;
            r_bit_idx      <= '0;
          end
        end
        ST_SHIFT: begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
          r_bit_idx <= r_bit_idx + 1'b1;
          if (w_last_bit) begin
            r_state        <= ST_DONE;
            r_chain_enable <= 1'b0;
            r_done         <= 1'b1;
          end else if (w_word_end) begin
            r_state        <= ST_LOAD;
            r_chain_enable <= 1'b0;
          end else begin
            r_chain_out <= r_shreg[0];
            r_shreg     <= r_shreg >> 1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign word_ready   = (r_state == ST_LOAD);
  assign busy         = (r_state != ST_IDLE);
  assign chain_out    = r_chain_out;
  assign chain_enable = r_chain_enable;
  assign chain_nreset = r_chain_nreset;
  assign done         = r_done;

`ifdef CONFIG_CHAIN_LOADER_READBACK_EN
  logic [WORD_WIDTH-1:0] r_rb_col;
  logic [WORD_WIDTH-1:0] r_rb_data;
  logic                  r_rb_valid;
  logic [WORD_WIDTH-1:0] w_rb_next;

  // Collector position tracks bit_idx, so a partial last word stays zero-filled above.
  assign w_rb_next = r_rb_col | (WORD_WIDTH'(chain_in) << r_bit_idx);

  always_ff @(posedge config_clock or posedge config_reset) begin
    if (config_reset) begin
      r_rb_col   <= '0;
      r_rb_data  <= '0;
      r_rb_valid <= 1'b0;
    end else begin
      r_rb_valid <= 1'b0;
      if (r_chain_enable) begin
        if (w_word_end) begin
          r_rb_data  <= w_rb_next;
          r_rb_valid <= 1'b1;
          r_rb_col   <= '0;
        end else begin
          r_rb_col <= w_rb_next;
        end
      end
    end
  end

  assign readback_data  = r_rb_data;
  assign readback_valid = r_rb_valid;
`else
  logic w_unused_chain_in;
  assign w_unused_chain_in = chain_in;
`endif

endmodule

// File: tb/tb_config_chain_loader.sv
// Bench for config_chain_loader: two instances (24-bit and 20-bit chains) driving a behavioural tile-chain model.
module tb_config_chain_loader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start_s [2];
  logic       clr_s   [2];
  logic       wv_s    [2];
  logic [7:0] wd_s    [2];
  logic       wr      [2];
  logic       co      [2];
  logic       ce      [2];
  logic       cn      [2];
  logic       ci      [2];
  logic       busy_o  [2];
  logic       done_o  [2];
`ifdef CONFIG_CHAIN_LOADER_READBACK_EN
  logic [7:0] rbd     [2];
  logic       rbv     [2];
  logic [7:0] rb_q[$];
`endif

  config_chain_loader #(.CHAIN_LENGTH(24), .WORD_WIDTH(8)) u_d24 (
    .config_clock(clk), .config_reset(rst), .start(start_s[0]), .clear_chain(clr_s[0]),
    .word_data(wd_s[0]), .word_valid(wv_s[0]), .word_ready(wr[0]), .chain_out(co[0]),
    .chain_enable(ce[0]), .chain_nreset(cn[0]), .chain_in(ci[0]),
`ifdef CONFIG_CHAIN_LOADER_READBACK_EN
    .readback_data(rbd[0]), .readback_valid(rbv[0]),
`endif
    .busy(busy_o[0]), .done(done_o[0])
  );

  config_chain_loader #(.CHAIN_LENGTH(20), .WORD_WIDTH(8)) u_d20 (
    .config_clock(clk), .config_reset(rst), .start(start_s[1]), .clear_chain(clr_s[1]),
    .word_data(wd_s[1]), .word_valid(wv_s[1]), .word_ready(wr[1]), .chain_out(co[1]),
    .chain_enable(ce[1]), .chain_nreset(cn[1]), .chain_in(ci[1]),
`ifdef CONFIG_CHAIN_LOADER_READBACK_EN
    .readback_data(rbd[1]), .readback_valid(rbv[1]),
`endif
    .busy(busy_o[1]), .done(done_o[1])
  );

  // Tile-chain model: position 0 is the first tile, position len-1 feeds chain_in.
  logic [23:0] chain_m [2] = '{24'h0, 24'h0};
  logic [23:0] pre_vec [2] = '{24'h0, 24'h0};
  logic        pre_en  [2] = '{1'b0, 1'b0};
  int en_cnt[2] = '{0, 0}, acc_cnt[2] = '{0, 0}, done_cnt[2] = '{0, 0};
  int nrl_cnt[2] = '{0, 0}, busy_cnt[2] = '{0, 0}, lat_err[2] = '{0, 0};
  logic pend[2] = '{1'b0, 1'b0}, pend_bit[2] = '{1'b0, 1'b0};

  assign ci[0] = chain_m[0][23];
  assign ci[1] = chain_m[1][19];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (pend[k] && !rst && !(ce[k] === 1'b1 && co[k] === pend_bit[k])) lat_err[k] <= lat_err[k] + 1;
      pend[k]     <= wv_s[k] && wr[k] && !rst;
      pend_bit[k] <= wd_s[k][0];
      if (cn[k] === 1'b0) begin
        nrl_cnt[k] <= nrl_cnt[k] + 1;
        chain_m[k] <= '0;
      end else if (ce[k] === 1'b1) begin
        en_cnt[k]  <= en_cnt[k] + 1;
        chain_m[k] <= {chain_m[k][22:0], co[k]};
      end else if (pre_en[k]) begin
        chain_m[k] <= pre_vec[k];
      end
      if (wv_s[k] && wr[k]) acc_cnt[k] <= acc_cnt[k] + 1;
      if (done_o[k] === 1'b1) done_cnt[k] <= done_cnt[k] + 1;
      if (busy_o[k] === 1'b1) busy_cnt[k] <= busy_cnt[k] + 1;
    end
`ifdef CONFIG_CHAIN_LOADER_READBACK_EN
    if (rbv[0] === 1'b1) rb_q.push_back(rbd[0]);
`endif
  end

  int n_pass = 0, n_total = 0;
  logic [7:0] words [3];
  int nw = 3;
  int t_nrl_first, t_rdy_first;
  int s_en, s_acc, s_done, s_nrl, s_busy, s_lat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int len_of(input int k);
    return (k == 0) ? 24 : 20;
  endfunction

  // Chain read as a number: the last tile holds bit 0.
  function automatic logic [23:0] chain_val(input int k);
    logic [23:0] v = '0;
    for (int p = 0; p < len_of(k); p++) v[len_of(k)-1-p] = chain_m[k][p];
    return v;
  endfunction

  function automatic logic [23:0] expected_chain(input int k);
    logic [23:0] all = {words[2], words[1], words[0]};
    return all & ((24'(1) << len_of(k)) - 24'(1)) | ((k == 0) ? all : 24'h0);
  endfunction

  task automatic snap(input int k);
    s_en = en_cnt[k]; s_acc = acc_cnt[k]; s_done = done_cnt[k];
    s_nrl = nrl_cnt[k]; s_busy = busy_cnt[k]; s_lat = lat_err[k];
  endtask

  task automatic idle_inputs();
    for (int k = 0; k < 2; k++) begin
      start_s[k] = 1'b0; clr_s[k] = 1'b0; wv_s[k] = 1'b0; wd_s[k] = 8'h00;
    end
  endtask

  task automatic reset_checks(input string tag, input int k);
    check({tag, "_word_ready"}, 32'(wr[k]), 32'd0);
    check({tag, "_chain_out"}, 32'(co[k]), 32'd0);
    check({tag, "_chain_enable"}, 32'(ce[k]), 32'd0);
    check({tag, "_chain_nreset"}, 32'(cn[k]), 32'd1);
    check({tag, "_busy"}, 32'(busy_o[k]), 32'd0);
    check({tag, "_done"}, 32'(done_o[k]), 32'd0);
  endtask

  // gapmode: 0 valid always high, 1 random gaps, 2 five-cycle drop before word 1.
  task automatic run_load(input int k, input bit clr, input int gapmode, input bit spur, input int abort_at);
    int idx = 0, cyc = 0, gap_left = 5;
    bit saw_done = 1'b0, hs;
    t_nrl_first = -1; t_rdy_first = -1;
    @(negedge clk);
    start_s[k] = 1'b1; clr_s[k] = clr; wv_s[k] = 1'b1; wd_s[k] = 8'hEE;
    @(negedge clk);
    start_s[k] = 1'b0; clr_s[k] = 1'b0;
    while (!saw_done && cyc < 2000) begin
      start_s[k] = spur && (cyc == 12);
      clr_s[k]   = start_s[k];
      if (cn[k] === 1'b0 && t_nrl_first < 0) t_nrl_first = cyc;
      if (wr[k] === 1'b1 && t_rdy_first < 0) t_rdy_first = cyc;
      if (abort_at > 0 && cyc == abort_at) begin
        check("t5_in_shift", 32'(ce[k]), 32'd1);
        rst = 1'b1;
        #1;
        reset_checks("t5_reset", k);
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        return;
      end
      wd_s[k] = (idx < nw) ? words[idx] : 8'h00;
      wv_s[k] = (idx < nw);
      if (gapmode == 1 && $urandom_range(0, 2) == 0) wv_s[k] = 1'b0;
      if (gapmode == 2 && idx == 1 && wr[k] === 1'b1 && gap_left > 0) begin
        wv_s[k] = 1'b0;
        gap_left--;
        check("t4_gap_enable_low", 32'(ce[k]), 32'd0);
      end
      hs = wv_s[k] && (wr[k] === 1'b1);
      saw_done = (done_o[k] === 1'b1);
      @(negedge clk);
      if (hs) idx++;
      cyc++;
    end
    idle_inputs();
    check("load_done_seen", 32'(saw_done), 32'd1);
  endtask

  task automatic check_load(input string tag, input int k, input bit clr, input bit full_valid);
    check({tag, "_chain"}, 32'(chain_val(k)), 32'(expected_chain(k)));
    check({tag, "_enable_cycles"}, 32'(en_cnt[k] - s_en), 32'(len_of(k)));
    check({tag, "_words_accepted"}, 32'(acc_cnt[k] - s_acc), 32'((len_of(k) + 7) / 8));
    check({tag, "_done_pulses"}, 32'(done_cnt[k] - s_done), 32'd1);
    check({tag, "_nreset_low"}, 32'(nrl_cnt[k] - s_nrl), 32'(clr));
    check({tag, "_latency"}, 32'(lat_err[k] - s_lat), 32'd0);
    if (full_valid)
      check({tag, "_busy_cycles"}, 32'(busy_cnt[k] - s_busy),
            32'(len_of(k) + (len_of(k) + 7) / 8 + 1 + int'(clr)));
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    reset_checks("reset0", 0);
    reset_checks("reset1", 1);
    rst = 1'b0;
    @(negedge clk);

    // T1: fixed words, valid always high, no clear.
    words = '{8'hA5, 8'h3C, 8'hF0};
    snap(0);
    run_load(0, 1'b0, 0, 1'b0, 0);
    check("t1_chain_value", 32'(chain_val(0)), 32'hF03CA5);
    check_load("t1", 0, 1'b0, 1'b1);
    check("t3_noclear_nreset", 32'(t_nrl_first), 32'hFFFF_FFFF);

    // T2 + T3: 20-bit chain, partial last word, with clear.
    words = '{8'($urandom), 8'($urandom), 8'($urandom)};
    snap(1);
    run_load(1, 1'b1, 0, 1'b0, 0);
    check_load("t2", 1, 1'b1, 1'b1);
    check("t3_nreset_cycle", 32'(t_nrl_first), 32'd0);
    check("t3_first_ready", 32'(t_rdy_first), 32'd1);

    // T4: valid gap mid-load plus a start pulse that must be ignored.
    words = '{8'hA5, 8'h3C, 8'hF0};
    snap(0);
    run_load(0, 1'b0, 2, 1'b1, 0);
    check("t4_chain_value", 32'(chain_val(0)), 32'hF03CA5);
    check_load("t4", 0, 1'b0, 1'b0);

    // T5: reset during shift, then a clean reload.
    words = '{8'h5A, 8'hC3, 8'h0F};
    run_load(0, 1'b0, 0, 1'b0, 4);
    words = '{8'hA5, 8'h3C, 8'hF0};
    snap(0);
    run_load(0, 1'b0, 0, 1'b0, 0);
    check("t5_reload_chain", 32'(chain_val(0)), 32'hF03CA5);
    check_load("t5", 0, 1'b0, 1'b1);

    // Randomized loads against the concatenation model.
    for (int i = 0; i < 6; i++) begin
      int k = i % 2;
      bit clr = 1'($urandom_range(0, 1));
      words = '{8'($urandom), 8'($urandom), 8'($urandom)};
      snap(k);
      run_load(k, clr, 1, 1'b0, 0);
      check_load($sformatf("rand%0d", i), k, clr, 1'b0);
    end

`ifdef CONFIG_CHAIN_LOADER_READBACK_EN
    // T6: old content comes back out while the new content loads.
    begin
      int base;
      logic [23:0] pv = 24'h123456;
      for (int p = 0; p < 24; p++) pre_vec[0][23-p] = pv[p];
      @(negedge clk);
      pre_en[0] = 1'b1;
      @(negedge clk);
      pre_en[0] = 1'b0;
      check("t6_preload", 32'(chain_val(0)), 32'h123456);
      base = rb_q.size();
      words = '{8'hFF, 8'hFF, 8'hFF};
      run_load(0, 1'b0, 0, 1'b0, 0);
      check("t6_rb_count", 32'(rb_q.size() - base), 32'd3);
      if (rb_q.size() >= base + 3) begin
        check("t6_rb0", 32'(rb_q[base]), 32'h56);
        check("t6_rb1", 32'(rb_q[base+1]), 32'h34);
        check("t6_rb2", 32'(rb_q[base+2]), 32'h12);
      end
      check("t6_chain", 32'(chain_val(0)), 32'hFFFFFF);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
